// File: rtl/deconv_sequencer.sv
// Run-level controller for deconv2D: loads kernel then image from one host stream, waits for done, drains the output map.
// Optional WAIT_DONE watchdog with sticky error flag is enabled by defining DECONV_SEQ_TIMEOUT_EN.
module deconv_sequencer #(
   parameter int N              = 2,
   parameter int K              = 3,
   parameter int PIXEL_WIDTH    = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [PIXEL_WIDTH-1:0]         s_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [PIXEL_WIDTH-1:0]         m_data,
   output logic                           m_last,
   output logic                           busy,
   output logic                           error,
   output logic                           dc_enable,
   output logic                           dc_load_kernel,
   output logic                           dc_load_input,
   output logic [PIXEL_WIDTH-1:0]         dc_kernel_in,
   output logic [PIXEL_WIDTH-1:0]         dc_image_in,
   input  logic                           dc_kernel_ready,
   input  logic                           dc_input_ready,
   input  logic                           dc_done,
   output logic [$clog2(N*K*N*K)-1:0]     out_idx,
   input  logic [PIXEL_WIDTH-1:0]         feature_in
);

   localparam int KK      = K * K;
   localparam int NN      = N * N;
   localparam int OUT_PIX = N * K * N * K;
   localparam int IDX_W   = $clog2(OUT_PIX);
   localparam int MAXB    = (KK > NN) ? KK : NN;
   localparam int CNT_W   = $clog2(MAXB + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_LOAD_K    = 3'd2;
   localparam logic [2:0] S_LOAD_I    = 3'd3;
   localparam logic [2:0] S_WAIT_DONE = 3'd4;
   localparam logic [2:0] S_DRAIN     = 3'd5;

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_out_idx;
   logic             w_load_k;
   logic             w_load_i;
   logic             w_out_last;
   logic             w_timeout;

   assign w_load_k   = (r_state == S_LOAD_K) && s_valid && dc_kernel_ready;
   assign w_load_i   = (r_state == S_LOAD_I) && s_valid && dc_input_ready;
   assign w_out_last = (r_out_idx == IDX_W'(OUT_PIX - 1));

   always_comb begin
      s_ready = 1'b0;
      if (r_state == S_LOAD_K)
         s_ready = dc_kernel_ready;
      else if (r_state == S_LOAD_I)
         s_ready = dc_input_ready;
   end

   assign dc_enable      = (r_state == S_START);
   assign dc_load_kernel = w_load_k;
   assign dc_load_input  = w_load_i;
   // Data buses follow the host beat unconditionally; the load strobes qualify them.
   assign dc_kernel_in   = s_data;
   assign dc_image_in    = s_data;

   assign m_valid = (r_state == S_DRAIN);
   assign m_data  = m_valid ? feature_in : '0;
   assign m_last  = m_valid && w_out_last;
   assign busy    = (r_state != S_IDLE);
   assign out_idx = r_out_idx;

`ifdef DECONV_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_error;

   assign w_timeout = (r_state == S_WAIT_DONE) && !dc_done
                      && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign error     = r_error;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt <= '0;
         r_error  <= 1'b0;
      end else begin
         if (r_state == S_WAIT_DONE)
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
         else
            r_wd_cnt <= '0;

         if (r_state == S_IDLE && start)
            r_error <= 1'b0;
         else if (w_timeout)
            r_error <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign error     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_out_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start)
                  r_state <= S_START;
            end
            S_START: begin
               r_state <= S_LOAD_K;
               r_cnt   <= '0;
            end
            S_LOAD_K: begin
               if (w_load_k) begin
                  if (r_cnt == CNT_W'(KK - 1)) begin
                     r_cnt   <= '0;
                     r_state <= S_LOAD_I;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_LOAD_I: begin
               if (w_load_i) begin
                  if (r_cnt == CNT_W'(NN - 1)) begin
                     r_cnt   <= '0;
                     r_state <= S_WAIT_DONE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_WAIT_DONE: begin
               if (dc_done) begin
                  r_state   <= S_DRAIN;
                  r_out_idx <= '0;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (m_ready) begin
                  if (w_out_last)
                     r_state <= S_IDLE;
                  else
                     r_out_idx <= r_out_idx + IDX_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_deconv_sequencer.sv
// Directed bench for deconv_sequencer (N=2, K=3); the deconv2D side is modelled by bench-driven ready/done and an index-derived feature mux.
module tb_deconv_sequencer;

   localparam int PW    = 8;
   localparam int IDX_W = 6;
   localparam int OUTN  = 36;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [PW-1:0]    s_data = '0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [PW-1:0]    m_data;
   logic             m_last;
   logic             busy;
   logic             error;
   logic             dc_enable;
   logic             dc_load_kernel;
   logic             dc_load_input;
   logic [PW-1:0]    dc_kernel_in;
   logic [PW-1:0]    dc_image_in;
   logic             dc_kernel_ready = 1'b1;
   logic             dc_input_ready = 1'b1;
   logic             dc_done = 1'b0;
   logic [IDX_W-1:0] out_idx;
   logic [PW-1:0]    feature_in;

   int tests_run = 0;
   int tests_failed = 0;

   // cumulative observations written only by the monitor
   int n_en = 0, n_lk = 0, n_li = 0, n_out = 0;
   int n_bad_idx = 0, n_bad_dat = 0, n_bad_last = 0, n_bad_kdat = 0, n_bad_strobe = 0;

   deconv_sequencer #(.N(2), .K(3), .PIXEL_WIDTH(PW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .error(error),
      .dc_enable(dc_enable), .dc_load_kernel(dc_load_kernel), .dc_load_input(dc_load_input),
      .dc_kernel_in(dc_kernel_in), .dc_image_in(dc_image_in),
      .dc_kernel_ready(dc_kernel_ready), .dc_input_ready(dc_input_ready), .dc_done(dc_done),
      .out_idx(out_idx), .feature_in(feature_in)
   );

   always #5 clk = ~clk;

   assign feature_in = PW'(int'(out_idx) * 7 + 5);

   always @(negedge clk) begin
      if (!rst) begin
         if (dc_enable) n_en++;
         if (dc_load_kernel) begin
            if (int'(dc_kernel_in) != (n_lk % 9) + 1) n_bad_kdat++;
            n_lk++;
         end
         if (dc_load_input) n_li++;
         if ((dc_load_kernel && !dc_kernel_ready) || (dc_load_input && !dc_input_ready))
            n_bad_strobe++;
         if (m_valid && m_ready) begin
            if (int'(out_idx) != n_out % OUTN) n_bad_idx++;
            if (m_data != PW'((n_out % OUTN) * 7 + 5)) n_bad_dat++;
            if (m_last != ((n_out % OUTN) == OUTN - 1)) n_bad_last++;
            n_out++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check("start_enable", dc_enable, 1);
      check("start_busy", busy, 1);
      tick();
   endtask

   task automatic feed(input bit img, input int nbeats, input int stall_at);
      for (int i = 0; i < nbeats; i++) begin
         s_valid = 1'b1;
         s_data  = PW'(i + 1);
         if (i == stall_at) begin
            if (img) dc_input_ready = 1'b0;
            else     dc_kernel_ready = 1'b0;
            repeat (5) begin
               #1;
               check("stall_s_ready", s_ready, 0);
               check("stall_strobe", dc_load_kernel | dc_load_input, 0);
               tick();
            end
            dc_kernel_ready = 1'b1;
            dc_input_ready  = 1'b1;
         end
         tick();
      end
      s_valid = 1'b0;
      s_data  = '0;
   endtask

   // WAIT_DONE probing, done pulse, then drain with optional m_ready toggling
   task automatic finish_run(input bit toggle);
      int base;
      int cyc;
      base = n_out;
      cyc  = 0;
      s_valid = 1'b1;
      s_data  = 8'h55;
      #1;
      check("wait_s_ready", s_ready, 0);
      check("wait_no_load", dc_load_kernel | dc_load_input, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check("busy_start_no_enable", dc_enable, 0);
      check("busy_start_busy", busy, 1);
      check("busy_start_no_mvalid", m_valid, 0);
      tick();
      s_valid = 1'b0;
      s_data  = '0;
      dc_done = 1'b1;
      tick();
      dc_done = 1'b0;
      check("drain_first_idx", out_idx, 0);
      check("drain_m_valid", m_valid, 1);
      while ((n_out - base) < OUTN && cyc < 300) begin
         m_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
         #1;
         if (!m_ready) check("hold_out_idx", out_idx, n_out - base);
         tick();
         cyc++;
      end
      m_ready = 1'b0;
      check("drain_beats", n_out - base, OUTN);
      check("post_drain_busy", busy, 0);
      check("post_drain_m_valid", m_valid, 0);
   endtask

   task automatic full_run(input int kstall, input bit toggle);
      int e0, k0, i0;
      e0 = n_en; k0 = n_lk; i0 = n_li;
      start_run();
      feed(1'b0, 9, kstall);
      check("image_after_kernel", n_li - i0, 0);
      check("kernel_beats", n_lk - k0, 9);
      feed(1'b1, 4, -1);
      check("image_beats", n_li - i0, 4);
      finish_run(toggle);
      check("enable_pulses", n_en - e0, 1);
      check("kernel_total", n_lk - k0, 9);
      check("image_total", n_li - i0, 4);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_data", m_data, 0);
      check("rst_enable", dc_enable, 0);
      check("rst_error", error, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_loads", dc_load_kernel | dc_load_input, 0);
      tick();
      rst = 1'b0;
      tick();
      s_valid = 1'b1;
      s_data  = 8'h11;
      #1;
      check("idle_s_ready", s_ready, 0);
      check("idle_no_load", dc_load_kernel, 0);
      s_valid = 1'b0;
      s_data  = '0;
      tick();

      full_run(-1, 1'b0);
      full_run(4, 1'b0);
      full_run(-1, 1'b1);

      // reset abandons a partial image load
      start_run();
      feed(1'b0, 9, -1);
      feed(1'b1, 2, -1);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_enable", dc_enable, 0);
      check("midrst_out_idx", out_idx, 0);
      tick();
      rst = 1'b0;
      tick();
      full_run(-1, 1'b0);

      // withheld done: watchdog behaviour depends on the build
      start_run();
      feed(1'b0, 9, -1);
      feed(1'b1, 4, -1);
      repeat (15) tick();
      check("wd_pre_error", error, 0);
      check("wd_pre_busy", busy, 1);
      tick();
`ifdef DECONV_SEQ_TIMEOUT_EN
      check("wd_error_set", error, 1);
      check("wd_idle", busy, 0);
      check("wd_no_drain", m_valid, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("wd_error_cleared", error, 0);
      check("wd_restart_busy", busy, 1);
`else
      repeat (20) tick();
      check("nowd_error", error, 0);
      check("nowd_still_waiting", busy, 1);
      check("nowd_no_drain", m_valid, 0);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("final_idle", busy, 0);

      check("mon_out_idx_order", n_bad_idx, 0);
      check("mon_out_data", n_bad_dat, 0);
      check("mon_m_last", n_bad_last, 0);
      check("mon_kernel_data", n_bad_kdat, 0);
      check("mon_strobe_gating", n_bad_strobe, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
